// File: rtl/tm1638_display_arbiter.sv
// Round-robin time-slicing of four display sources onto one TM1638 LED/key driver.
// Optional feature macro ARB_KEY_PIN_EN: board keys 0-3 pin a requesting source to the display.
module tm1638_display_arbiter #(
  parameter int C_FCK      = 50_000_000,
  parameter int C_DWELL_MS = 1000
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [3:0]   req_i,
  input  logic [127:0] bin_dat_i,
  input  logic [31:0]  leds_i,
  input  logic [31:0]  dots_i,
  input  logic [7:0]   keys_i,
  output logic [31:0]  bin_dat_o,
  output logic [7:0]   leds_o,
  output logic [7:0]   dots_o,
  output logic [3:0]   grant_o,
  output logic         pinned_o,
  output logic         upd_o
);

  localparam int DWELL_CYC = (C_FCK / 1000) * C_DWELL_MS;
  localparam int CNT_W     = $clog2(DWELL_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_BLANK  = 2'd0,
    ST_SHOW   = 2'd1,
    ST_PINNED = 2'd2
  } state_t;

  // Returns {found, index} of the first set bit of req scanning upward (mod 4) from start.
  function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = start + 2'(i);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  state_t           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       grant_q, grant_d;
  logic [31:0]      bin_dat_q, bin_dat_d;
  logic [7:0]       leds_q, leds_d;
  logic [7:0]       dots_q, dots_d;
  logic             pinned_q, pinned_d;
  logic             upd_q, upd_d;

  logic [2:0]       scan_rr_s;
  logic [2:0]       scan_nx_s;
  logic             press_ok_s;
  logic [1:0]       press_idx_s;
  logic             unused_keys_s;

  assign scan_rr_s = pick(req_i, rr_q);
  assign scan_nx_s = pick(req_i, owner_q + 2'd1);

`ifdef ARB_KEY_PIN_EN
  localparam bit PIN_EN_C = 1'b1;
  logic [3:0] keys_q;
  logic [2:0] press_pick_s;

  // A press is a rising edge against the previous cycle's key levels; lowest index wins.
  assign press_pick_s  = pick(keys_i[3:0] & ~keys_q, 2'd0);
  assign press_idx_s   = press_pick_s[1:0];
  assign press_ok_s    = press_pick_s[2] & req_i[press_pick_s[1:0]];
  assign unused_keys_s = ^keys_i[7:4];

  // Key history register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      keys_q <= 4'b0000;
    end else begin
      keys_q <= keys_i[3:0];
    end
  end
`else
  localparam bit PIN_EN_C = 1'b0;
  assign press_ok_s    = 1'b0;
  assign press_idx_s   = 2'd0;
  assign unused_keys_s = ^keys_i;
`endif

  // Next owner, slot timing and the registered image of the owner's data.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (press_ok_s) begin
      // A valid press outranks dwell expiry and owner drop.
      cnt_d   = CNT_ZERO;
      owner_d = press_idx_s;
      if ((state_q == ST_PINNED) && (owner_q == press_idx_s)) begin
        state_d = ST_SHOW;
      end else begin
        state_d = ST_PINNED;
      end
    end else begin
      case (state_q)
        ST_BLANK: begin
          cnt_d = CNT_ZERO;
          if (scan_rr_s[2]) begin
            state_d = ST_SHOW;
            owner_d = scan_rr_s[1:0];
          end else begin
            state_d = ST_BLANK;
          end
        end
        ST_SHOW: begin
          if (!req_i[owner_q] || (cnt_q == CNT_LAST)) begin
            cnt_d = CNT_ZERO;
            if (scan_nx_s[2]) begin
              state_d = ST_SHOW;
              owner_d = scan_nx_s[1:0];
            end else begin
              state_d = ST_BLANK;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_PINNED: begin
          cnt_d = CNT_ZERO;
          if (!req_i[owner_q]) begin
            if (scan_nx_s[2]) begin
              state_d = ST_SHOW;
              owner_d = scan_nx_s[1:0];
            end else begin
              state_d = ST_BLANK;
            end
          end else begin
            state_d = ST_PINNED;
          end
        end
        default: begin
          state_d = ST_BLANK;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end

    grant_d   = 4'b0000;
    bin_dat_d = 32'h0000_0000;
    leds_d    = 8'h00;
    dots_d    = 8'h00;
    pinned_d  = 1'b0;
    rr_d      = rr_q;
    if (state_d != ST_BLANK) begin
      grant_d   = 4'b0001 << owner_d;
      bin_dat_d = bin_dat_i[{owner_d, 5'b00000} +: 32];
      leds_d    = leds_i[{owner_d, 3'b000} +: 8];
      dots_d    = dots_i[{owner_d, 3'b000} +: 8];
      pinned_d  = PIN_EN_C & (state_d == ST_PINNED);
      rr_d      = owner_d + 2'd1;
    end else begin
      rr_d      = rr_q;
    end
    upd_d = (grant_d != grant_q);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_BLANK;
      owner_q   <= 2'd0;
      rr_q      <= 2'd0;
      cnt_q     <= CNT_ZERO;
      grant_q   <= 4'b0000;
      bin_dat_q <= 32'h0000_0000;
      leds_q    <= 8'h00;
      dots_q    <= 8'h00;
      pinned_q  <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      bin_dat_q <= bin_dat_d;
      leds_q    <= leds_d;
      dots_q    <= dots_d;
      pinned_q  <= pinned_d;
      upd_q     <= upd_d;
    end
  end

  assign grant_o   = grant_q;
  assign bin_dat_o = bin_dat_q;
  assign leds_o    = leds_q;
  assign dots_o    = dots_q;
  assign pinned_o  = pinned_q;
  assign upd_o     = upd_q;

endmodule

// File: tb/tb_tm1638_display_arbiter.sv
// Self-checking bench for tm1638_display_arbiter: directed scenarios plus randomized
// stimulus against a slot-level behavioural model (DWELL = 10 cycles).
`timescale 1ns/1ps
module tb_tm1638_display_arbiter;

  localparam int DWELL = 10;
`ifdef ARB_KEY_PIN_EN
  localparam bit PIN_EN = 1'b1;
`else
  localparam bit PIN_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic [3:0]   req_i;
  logic [127:0] bin_dat_i;
  logic [31:0]  leds_i;
  logic [31:0]  dots_i;
  logic [7:0]   keys_i;
  logic [31:0]  bin_dat_o;
  logic [7:0]   leds_o;
  logic [7:0]   dots_o;
  logic [3:0]   grant_o;
  logic         pinned_o;
  logic         upd_o;

  always #5 clk = ~clk;

  tm1638_display_arbiter #(.C_FCK(1000), .C_DWELL_MS(10)) dut (
    .clk(clk), .n_rst(n_rst), .req_i(req_i), .bin_dat_i(bin_dat_i),
    .leds_i(leds_i), .dots_i(dots_i), .keys_i(keys_i),
    .bin_dat_o(bin_dat_o), .leds_o(leds_o), .dots_o(dots_o),
    .grant_o(grant_o), .pinned_o(pinned_o), .upd_o(upd_o)
  );

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state: owner index (-1 = blank), cycles spent in current slot, pin flag, rr pointer.
  int         m_owner;
  int         m_age;
  int         m_rr;
  bit         m_pin;
  logic [3:0] m_keys;
  logic [3:0] e_grant;
  logic [31:0] e_bin;
  logic [7:0] e_leds, e_dots;
  logic       e_pin, e_upd;

  function automatic int first_req(input logic [3:0] req, input int from);
    for (int off = 0; off < 4; off++) begin
      if (req[(from + off) % 4]) return (from + off) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_rr = 0; m_pin = 1'b0; m_keys = 4'b0000;
    e_grant = 4'b0000; e_bin = 32'h0; e_leds = 8'h0; e_dots = 8'h0;
    e_pin = 1'b0; e_upd = 1'b0;
  endtask

  task automatic model_step();
    int nw;
    int press;
    bit np;
    bit restart;
    logic [3:0] ng;
    nw = m_owner; np = m_pin; restart = 1'b0; press = -1;
    if (PIN_EN) begin
      for (int k = 3; k >= 0; k--) begin
        if (keys_i[k] && !m_keys[k]) press = k;
      end
    end
    m_keys = keys_i[3:0];
    if (press >= 0 && req_i[press]) begin
      nw = press; restart = 1'b1; np = !(m_pin && m_owner == press);
    end else if (m_owner < 0) begin
      nw = first_req(req_i, m_rr); restart = 1'b1; np = 1'b0;
    end else if (!req_i[m_owner] || (!m_pin && m_age == DWELL - 1)) begin
      nw = first_req(req_i, m_owner + 1); restart = 1'b1; np = 1'b0;
    end
    if (nw < 0) np = 1'b0;
    if (nw < 0 || restart || np) m_age = 0;
    else m_age = m_age + 1;
    if (nw >= 0) m_rr = (nw + 1) % 4;
    m_owner = nw; m_pin = np;
    ng = (nw < 0) ? 4'b0000 : (4'b0001 << nw);
    e_upd  = (ng != e_grant);
    e_grant = ng;
    e_bin  = (nw < 0) ? 32'h0 : bin_dat_i[32*nw +: 32];
    e_leds = (nw < 0) ? 8'h0 : leds_i[8*nw +: 8];
    e_dots = (nw < 0) ? 8'h0 : dots_i[8*nw +: 8];
    e_pin  = np;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (n_rst) model_step();
      @(negedge clk);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({grant_o, bin_dat_o, leds_o, dots_o, pinned_o, upd_o} !==
          {e_grant, e_bin, e_leds, e_dots, e_pin, e_upd}) begin
        n_fail++;
        $display("FAIL model t=%0t: grant %b/%b bin %h/%h leds %h/%h dots %h/%h pin %b/%b upd %b/%b (got/expected)",
                 $time, grant_o, e_grant, bin_dat_o, e_bin, leds_o, e_leds, dots_o, e_dots,
                 pinned_o, e_pin, upd_o, e_upd);
      end
    end
  end

  task automatic async_reset_check();
    #2 n_rst = 1'b0;
    #1;
    chk("rst_grant", {28'd0, grant_o}, 32'd0);
    chk("rst_bin", bin_dat_o, 32'd0);
    chk("rst_ledsdots", {16'd0, leds_o, dots_o}, 32'd0);
    chk("rst_pin_upd", {30'd0, pinned_o, upd_o}, 32'd0);
    model_reset();
  endtask

  initial begin
    req_i = 4'b0000; keys_i = 8'h00;
    bin_dat_i = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    leds_i = 32'h8040_2010; dots_i = 32'h0804_0201;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk_en = 1'b1;
    chk("reset_grant", {28'd0, grant_o}, 32'd0);
    chk("reset_bin", bin_dat_o, 32'd0);

    // Full rotation, each slot held DWELL cycles.
    n_rst = 1'b1; req_i = 4'b1111;
    tick(1);
    chk("first_grant", {28'd0, grant_o}, 32'h1);
    chk("first_upd", {31'd0, upd_o}, 32'h1);
    chk("first_bin", bin_dat_o, 32'hAAAA_0000);
    chk("first_leds", {24'd0, leds_o}, 32'h10);
    tick(9);
    chk("hold_grant", {28'd0, grant_o}, 32'h1);
    chk("hold_upd", {31'd0, upd_o}, 32'h0);
    tick(1);
    chk("rot1_grant", {28'd0, grant_o}, 32'h2);
    chk("rot1_upd", {31'd0, upd_o}, 32'h1);
    chk("rot1_bin", bin_dat_o, 32'hBBBB_0001);
    tick(10); chk("rot2_grant", {28'd0, grant_o}, 32'h4);
    tick(10); chk("rot3_grant", {28'd0, grant_o}, 32'h8);
    tick(10); chk("rot4_grant", {28'd0, grant_o}, 32'h1);

    // Single requester: self-regrant across several expiries, then blank.
    req_i = 4'b0100;
    tick(1); chk("solo_grant", {28'd0, grant_o}, 32'h4);
    tick(25);
    chk("solo_hold", {28'd0, grant_o}, 32'h4);
    chk("solo_noupd", {31'd0, upd_o}, 32'h0);
    req_i = 4'b0000;
    tick(1);
    chk("blank_grant", {28'd0, grant_o}, 32'h0);
    chk("blank_bin", bin_dat_o, 32'h0);
    chk("blank_upd", {31'd0, upd_o}, 32'h1);

    // Owner drops mid-slot.
    req_i = 4'b1011;
    tick(1); chk("rr_from_blank", {28'd0, grant_o}, 32'h8);
    tick(10); chk("owner0", {28'd0, grant_o}, 32'h1);
    tick(3);
    req_i = 4'b1010;
    tick(1); chk("drop_switch", {28'd0, grant_o}, 32'h2);

`ifdef ARB_KEY_PIN_EN
    req_i = 4'b1111; keys_i = 8'h08;
    tick(1);
    chk("pin_grant", {28'd0, grant_o}, 32'h8);
    chk("pin_flag", {31'd0, pinned_o}, 32'h1);
    tick(50);
    chk("pin_hold", {28'd0, grant_o}, 32'h8);
    keys_i = 8'h00; tick(1);
    keys_i = 8'h08; tick(1);
    chk("unpin_flag", {31'd0, pinned_o}, 32'h0);
    chk("unpin_grant", {28'd0, grant_o}, 32'h8);
    tick(9); chk("unpin_dwell", {28'd0, grant_o}, 32'h8);
    tick(1); chk("unpin_rot", {28'd0, grant_o}, 32'h1);
    keys_i = 8'h00; req_i = 4'b1011; tick(1);
    keys_i = 8'h04; tick(1);
    chk("ign_grant", {28'd0, grant_o}, 32'h1);
    chk("ign_pin", {31'd0, pinned_o}, 32'h0);
    keys_i = 8'h06; tick(1);
    chk("pin1_grant", {28'd0, grant_o}, 32'h2);
    chk("pin1_flag", {31'd0, pinned_o}, 32'h1);
`endif

    // Async reset mid-slot (pinned when the feature is built in).
    tick(4);
    async_reset_check();
    req_i = 4'b0010; keys_i = 8'h00;
    @(negedge clk);
    n_rst = 1'b1;
    tick(1);
    chk("post_rst_grant", {28'd0, grant_o}, 32'h2);
    chk("post_rst_upd", {31'd0, upd_o}, 32'h1);

    // Randomized phase.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) req_i = 4'($urandom);
      bin_dat_i = {$urandom, $urandom, $urandom, $urandom};
      leds_i = $urandom;
      dots_i = $urandom;
      if ($urandom_range(0, 7) == 0) keys_i = 8'($urandom);
      else if ($urandom_range(0, 3) == 0) keys_i = 8'h00;
      if ($urandom_range(0, 499) == 0) begin
        async_reset_check();
        @(negedge clk);
        n_rst = 1'b1;
      end
      tick(1);
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
